proc_control: RTL and testbench

PROC_CONTROL -- requirements
Module: proc_control

---
 rtl/proc_control.sv | 113 +++++++++++
 tb/tb_proc_control.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/proc_control.sv
// Instruction-sequencing FSM for a small 8-register datapath: mv/mvi finish one cycle
// after the run-accept edge, add/sub three; run is only sampled while idle in T0.
module proc_control (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [15:0] din,
  output logic        ir_en,
  output logic [7:0]  r_en,
  output logic        a_en,
  output logic        g_en,
  output logic [3:0]  bus_sel,
  output logic        add_sub,
  output logic        done,
  output logic        busy
);

  typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  localparam logic [3:0] SEL_G   = 4'd8;
  localparam logic [3:0] SEL_DIN = 4'd9;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;

  logic [2:0] opcode;
  logic [2:0] rx;
  logic [2:0] ry;

  assign opcode = ir_q[15:13];
  assign rx     = ir_q[12:10];
  assign ry     = ir_q[9:7];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= T0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Everything is gated by reset so run cannot leak through to ir_en while reset is held.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    ir_en   = 1'b0;
    r_en    = 8'h00;
    a_en    = 1'b0;
    g_en    = 1'b0;
    bus_sel = SEL_DIN;
    add_sub = 1'b0;
    done    = 1'b0;
    busy    = (state_q != T0);

    if (!reset) begin
      case (state_q)
        T0: begin
          if (run) begin
            ir_en   = 1'b1;
            ir_d    = din;
            state_d = T1;
          end
        end
        T1: begin
          case (opcode)
            OP_MV: begin
              bus_sel = {1'b0, ry};
              r_en    = 8'd1 << rx;
              done    = 1'b1;
              state_d = T0;
            end
            OP_MVI: begin
              bus_sel = SEL_DIN;
              r_en    = 8'd1 << rx;
              done    = 1'b1;
              state_d = T0;
            end
            OP_ADD, OP_SUB: begin
              bus_sel = {1'b0, rx};
              a_en    = 1'b1;
              state_d = T2;
            end
            default: begin
              done    = 1'b1;
              state_d = T0;
            end
          endcase
        end
        T2: begin
          bus_sel = {1'b0, ry};
          g_en    = 1'b1;
          add_sub = opcode[0];
          state_d = T3;
        end
        T3: begin
          bus_sel = SEL_G;
          r_en    = 8'd1 << rx;
          done    = 1'b1;
          state_d = T0;
        end
        default: state_d = T0;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_control.sv
// Directed bench for proc_control: inputs change on the falling edge, outputs are
// compared 1ns later as one packed vector against hand-computed expectations.
module tb_proc_control;

  logic        clk;
  logic        reset;
  logic        run;
  logic [15:0] din;
  logic        ir_en;
  logic [7:0]  r_en;
  logic        a_en;
  logic        g_en;
  logic [3:0]  bus_sel;
  logic        add_sub;
  logic        done;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  proc_control dut (
    .clk     (clk),
    .reset   (reset),
    .run     (run),
    .din     (din),
    .ir_en   (ir_en),
    .r_en    (r_en),
    .a_en    (a_en),
    .g_en    (g_en),
    .bus_sel (bus_sel),
    .add_sub (add_sub),
    .done    (done),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {ir_en, r_en, a_en, g_en, bus_sel, add_sub, done, busy}
  function automatic logic [17:0] ev(input logic ir, input logic [7:0] r, input logic a,
                                     input logic g, input logic [3:0] bs, input logic as,
                                     input logic dn, input logic bz);
    return {ir, r, a, g, bs, as, dn, bz};
  endfunction

  function automatic logic [17:0] obs();
    return {ir_en, r_en, a_en, g_en, bus_sel, add_sub, done, busy};
  endfunction

  task automatic chk(input string tag, input logic [17:0] got, input logic [17:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %05h expected %05h (ir r a g sel as dn bz)", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic [15:0] d,
                      input logic [17:0] exp);
    @(negedge clk);
    run = r;
    din = d;
    #1;
    chk(tag, obs(), exp);
  endtask

  logic [17:0] DEF;
  logic [17:0] IR;

  initial begin
    DEF = ev(1'b0, 8'h00, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0);
    IR  = ev(1'b1, 8'h00, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0);

    reset = 1'b1;
    run   = 1'b1;
    din   = 16'h0E80;
    #1;
    chk("reset_run_hi", obs(), DEF);
    @(posedge clk);
    #1;
    chk("reset_held", obs(), DEF);
    @(negedge clk);
    reset = 1'b0;
    run   = 1'b0;
    #1;
    chk("post_reset_idle", obs(), DEF);

    // mv R3,R5
    step("mv_t0", 1'b1, 16'h0E80, IR);
    step("mv_t1", 1'b0, 16'h0000, ev(1'b0, 8'h08, 1'b0, 1'b0, 4'd5, 1'b0, 1'b1, 1'b1));
    step("mv_idle", 1'b0, 16'h0000, DEF);

    // mvi R1, 0x00AB
    step("mvi_t0", 1'b1, 16'h2400, IR);
    step("mvi_t1", 1'b0, 16'h00AB, ev(1'b0, 8'h02, 1'b0, 1'b0, 4'd9, 1'b0, 1'b1, 1'b1));

    // sub R0,R7
    step("sub_t0", 1'b1, 16'h6380, IR);
    step("sub_t1", 1'b0, 16'h0000, ev(1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1));
    step("sub_t2", 1'b0, 16'h0000, ev(1'b0, 8'h00, 1'b0, 1'b1, 4'd7, 1'b1, 1'b0, 1'b1));
    step("sub_t3", 1'b0, 16'h0000, ev(1'b0, 8'h01, 1'b0, 1'b0, 4'd8, 1'b0, 1'b1, 1'b1));
    step("sub_idle", 1'b0, 16'h0000, DEF);

    // add R2,R4 then mv R6,R2 back-to-back, run held high; din changes mid-add are ignored
    step("b2b_add_t0", 1'b1, 16'h4A00, IR);
    step("b2b_add_t1", 1'b1, 16'h1900, ev(1'b0, 8'h00, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1));
    step("b2b_add_t2", 1'b1, 16'h1900, ev(1'b0, 8'h00, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0, 1'b1));
    step("b2b_add_t3", 1'b1, 16'h1900, ev(1'b0, 8'h04, 1'b0, 1'b0, 4'd8, 1'b0, 1'b1, 1'b1));
    step("b2b_mv_t0", 1'b1, 16'h1900, IR);
    step("b2b_mv_t1", 1'b1, 16'h0E80, ev(1'b0, 8'h40, 1'b0, 1'b0, 4'd2, 1'b0, 1'b1, 1'b1));
    step("b2b_idle", 1'b0, 16'h0000, DEF);

    // reset asserted during T2 of add R2,R4
    step("rst_add_t0", 1'b1, 16'h4A00, IR);
    step("rst_add_t1", 1'b0, 16'h0000, ev(1'b0, 8'h00, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1));
    step("rst_add_t2", 1'b0, 16'h0000, ev(1'b0, 8'h00, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0, 1'b1));
    reset = 1'b1;
    #1;
    chk("rst_immediate", obs(), DEF);
    @(posedge clk);
    #1;
    chk("rst_no_done", obs(), DEF);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_released", obs(), DEF);
    step("rst_next_t0", 1'b1, 16'h0E80, IR);
    step("rst_next_t1", 1'b0, 16'h0000, ev(1'b0, 8'h08, 1'b0, 1'b0, 4'd5, 1'b0, 1'b1, 1'b1));

    // reserved opcode 110: single no-op cycle, run in T1 not queued
    step("rsv_t0", 1'b1, 16'hC000, IR);
    step("rsv_t1", 1'b1, 16'h2400, ev(1'b0, 8'h00, 1'b0, 1'b0, 4'd9, 1'b0, 1'b1, 1'b1));
    step("rsv_idle", 1'b0, 16'h0000, DEF);

    // add R2,R2: same sequence with rX == rY
    step("same_t0", 1'b1, 16'h4900, IR);
    step("same_t1", 1'b0, 16'h0000, ev(1'b0, 8'h00, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1));
    step("same_t2", 1'b0, 16'h0000, ev(1'b0, 8'h00, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1));
    step("same_t3", 1'b0, 16'h0000, ev(1'b0, 8'h04, 1'b0, 1'b0, 4'd8, 1'b0, 1'b1, 1'b1));
    step("same_idle", 1'b0, 16'h0000, DEF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
